register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the width of every register and data port.
REQ-002 Parameter NUM_REGS, default 8, SHALL set the number of registers (legal range 2..64).
REQ-003 Parameter ZERO_REG, default 0, SHALL make register 0 read as constant 0 and ignore writes to it when set to 1.
REQ-004 Parameter BYPASS, default 1, SHALL enable write-to-read forwarding when set to 1.
REQ-005 Derived ADDR_WIDTH SHALL be clog2(NUM_REGS), minimum 1.
REQ-006 iclk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 irst  input  1  SHALL be the reset, synchronous and active-high.
REQ-008 iwe  input  1  SHALL request a write-port operation this cycle.
REQ-009 iwaddr  input  ADDR_WIDTH  SHALL be the target register of the write-port operation.
REQ-010 iwmode  input  2  SHALL select the operation: 00 LOAD, 01 INC, 10 DEC, 11 CLR.
REQ-011 iwdata  input  DATA_WIDTH  SHALL be the LOAD value.
REQ-012 iraddr_a  input  ADDR_WIDTH  SHALL be the read-port A address.
REQ-013 iraddr_b  input  ADDR_WIDTH  SHALL be the read-port B address.
REQ-014 ordata_a  output  DATA_WIDTH  SHALL be the read-port A data.
REQ-015 ordata_b  output  DATA_WIDTH  SHALL be the read-port B data.
REQ-016 odirty  output  NUM_REGS  SHALL flag, per register, an effective write since the last reset.
REQ-017 ooverflow  output  1  SHALL be a registered one-cycle pulse flagging INC/DEC wrap-around.

Function
REQ-018 LOAD SHALL store iwdata into register iwaddr at the next rising edge.
REQ-019 INC SHALL store (R[iwaddr] + 1) mod 2^DATA_WIDTH; DEC SHALL store (R[iwaddr] - 1) mod 2^DATA_WIDTH; CLR SHALL store 0.
REQ-020 INC on all-ones or DEC on 0 SHALL assert ooverflow for exactly the following cycle; any other cycle SHALL drive ooverflow 0.
REQ-021 An effective write SHALL set odirty[iwaddr] at the same edge the register updates; odirty bits SHALL clear only on reset (CLR SHALL still set the bit).
REQ-022 A write is ineffective, with no state, odirty or ooverflow change, if iwe=0, if iwaddr >= NUM_REGS, or if ZERO_REG=1 and iwaddr=0.
REQ-023 Reads SHALL be combinational: ordata_x = R[iraddr_x] with zero cycles of latency.
REQ-024 A read of iraddr_x >= NUM_REGS, or of address 0 with ZERO_REG=1, SHALL return 0.
REQ-025 BYPASS=1: an effective write in the same cycle with iwaddr == iraddr_x SHALL drive ordata_x with the value being written (post-operation result).
REQ-026 BYPASS=0: ordata_x SHALL show the pre-write value during the write cycle and the new value from the next cycle onward.
REQ-027 Both read ports SHALL be independent; identical addresses SHALL return identical data.
REQ-028 Registers not addressed by an effective write SHALL hold their value.

Reset
REQ-029 irst=1 at a rising edge SHALL clear all registers, odirty and ooverflow to 0.
REQ-030 irst SHALL take priority over a simultaneous iwe; that write SHALL be discarded entirely.
REQ-031 While irst=1, forwarding SHALL be suppressed and reads SHALL return stored values.
REQ-032 The first write accepted after irst deasserts SHALL behave per REQ-018..REQ-022 with no extra latency.

Verification
REQ-033 Reset then LOAD R3=0x1234, read A=3 next cycle -> ordata_a=0x1234, odirty=8'b0000_1000.
REQ-034 LOAD R5=0xFFFF, then INC R5 -> R5=0x0000, ooverflow=1 for one cycle, then 0; DEC R5 -> 0xFFFF, ooverflow pulses again.
REQ-035 BYPASS=1, LOAD R2=0x00AA with iraddr_a=2, iraddr_b=2 in the same cycle -> both ports read 0x00AA that cycle; BYPASS=0 -> old value (0x0000) that cycle, 0x00AA next.
REQ-036 ZERO_REG=1, LOAD R0=0xBEEF -> ordata_a(addr 0)=0, odirty[0]=0, no ooverflow.
REQ-037 LOAD R1=0x5555, then irst=1 together with iwe LOAD R1=0x7777 -> R1=0, odirty=0, ooverflow=0.
REQ-038 NUM_REGS=6, LOAD at iwaddr=7 -> no register or odirty change; read at address 6 -> 0.

Source files
------------

// File: rtl/register_bank.sv
// Multi-register bank: one LOAD/INC/DEC/CLR write port, two combinational
// read ports with optional write forwarding, per-register dirty flags.
module register_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1,
  localparam int ADDR_WIDTH =
    ($clog2(NUM_REGS) < 1) ? 1 : $clog2(NUM_REGS)
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  iwe,
  input  logic [ADDR_WIDTH-1:0] iwaddr,
  input  logic [1:0]            iwmode,
  input  logic [DATA_WIDTH-1:0] iwdata,
  input  logic [ADDR_WIDTH-1:0] iraddr_a,
  input  logic [ADDR_WIDTH-1:0] iraddr_b,
  output logic [DATA_WIDTH-1:0] ordata_a,
  output logic [DATA_WIDTH-1:0] ordata_b,
  output logic [NUM_REGS-1:0]   odirty,
  output logic                  ooverflow
);

  typedef enum logic [1:0] {
    M_LOAD = 2'b00,
    M_INC  = 2'b01,
    M_DEC  = 2'b10,
    M_CLR  = 2'b11
  } wmode_e;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] cur;
  logic [DATA_WIDTH-1:0] wval;
  logic                  addr_ok;
  logic                  zero_hit;
  logic                  wr_eff;
  logic                  wrap;
  logic                  fwd;

  assign addr_ok  = 32'(iwaddr) < NUM_REGS;
  assign zero_hit = (ZERO_REG != 0) && (iwaddr == '0);
  assign wr_eff   = iwe && addr_ok && !zero_hit;
  assign fwd      = (BYPASS != 0) && wr_eff && !irst;

  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (iwaddr == ADDR_WIDTH'(i)) cur = regs[i];
    end
  end

  always_comb begin
    wval = '0;
    wrap = 1'b0;
    unique case (wmode_e'(iwmode))
      M_LOAD: wval = iwdata;
      M_INC: begin
        wval = cur + 1'b1;
        wrap = &cur;
      end
      M_DEC: begin
        wval = cur - 1'b1;
        wrap = (cur == '0);
      end
      M_CLR: wval = '0;
      default: wval = '0;
    endcase
  end

  // Reset wins over a simultaneous write; the write is dropped entirely.
  always_ff @(posedge iclk) begin
    if (irst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      odirty    <= '0;
      ooverflow <= 1'b0;
    end else begin
      ooverflow <= wr_eff && wrap;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_eff && iwaddr == ADDR_WIDTH'(i)) begin
          regs[i]   <= wval;
          odirty[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    ordata_a = '0;
    ordata_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!((ZERO_REG != 0) && (i == 0))) begin
        if (iraddr_a == ADDR_WIDTH'(i)) ordata_a = regs[i];
        if (iraddr_b == ADDR_WIDTH'(i)) ordata_b = regs[i];
      end
    end
    if (fwd && iraddr_a == iwaddr) ordata_a = wval;
    if (fwd && iraddr_b == iwaddr) ordata_b = wval;
  end

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: default instance driven from a vector
// table, plus a BYPASS=0 / ZERO_REG=1 / NUM_REGS=6 instance on shared inputs.
module tb_register_bank;

  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [1:0]  mode;
  logic [15:0] wdata;
  logic [2:0]  ra;
  logic [2:0]  rb;

  logic [15:0] rda0, rdb0, rda1, rdb1;
  logic [7:0]  dirty0;
  logic [5:0]  dirty1;
  logic        ovf0, ovf1;

  int checks = 0;
  int errors = 0;

  register_bank u0 (
    .iclk(clk), .irst(rst), .iwe(we), .iwaddr(waddr),
    .iwmode(mode), .iwdata(wdata),
    .iraddr_a(ra), .iraddr_b(rb),
    .ordata_a(rda0), .ordata_b(rdb0),
    .odirty(dirty0), .ooverflow(ovf0)
  );

  register_bank #(
    .NUM_REGS(6), .ZERO_REG(1), .BYPASS(0)
  ) u1 (
    .iclk(clk), .irst(rst), .iwe(we), .iwaddr(waddr),
    .iwmode(mode), .iwdata(wdata),
    .iraddr_a(ra), .iraddr_b(rb),
    .ordata_a(rda1), .ordata_b(rdb1),
    .odirty(dirty1), .ooverflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [2:0]  waddr;
    logic [1:0]  mode;
    logic [15:0] wdata;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [7:0]  edirty;
    logic        eovf;
  } vec_t;

  localparam int NV = 24;
  vec_t vt [NV];

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w,
                       input logic [2:0] wa, input logic [1:0] m,
                       input logic [15:0] d,
                       input logic [2:0] a, input logic [2:0] b);
    rst = r; we = w; waddr = wa; mode = m;
    wdata = d; ra = a; rb = b;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst we wa mode data ra rb | ea eb dirty ovf
    vt[0]  = '{0,0,3,2'd0,16'h0000,3,0, 16'h0000,16'h0000,8'h00,0};
    vt[1]  = '{0,1,3,2'd0,16'h1234,3,3, 16'h1234,16'h1234,8'h00,0};
    vt[2]  = '{0,0,0,2'd0,16'h0000,3,1, 16'h1234,16'h0000,8'h08,0};
    vt[3]  = '{0,1,5,2'd0,16'hFFFF,5,3, 16'hFFFF,16'h1234,8'h08,0};
    vt[4]  = '{0,1,5,2'd1,16'h0000,5,5, 16'h0000,16'h0000,8'h28,0};
    vt[5]  = '{0,0,0,2'd0,16'h0000,5,3, 16'h0000,16'h1234,8'h28,1};
    vt[6]  = '{0,1,5,2'd2,16'h0000,5,0, 16'hFFFF,16'h0000,8'h28,0};
    vt[7]  = '{0,0,0,2'd0,16'h0000,5,0, 16'hFFFF,16'h0000,8'h28,1};
    vt[8]  = '{0,0,0,2'd0,16'h0000,5,0, 16'hFFFF,16'h0000,8'h28,0};
    vt[9]  = '{0,1,3,2'd1,16'h0000,3,2, 16'h1235,16'h0000,8'h28,0};
    vt[10] = '{0,1,3,2'd2,16'h0000,3,2, 16'h1234,16'h0000,8'h28,0};
    vt[11] = '{0,1,3,2'd3,16'hFFFF,3,3, 16'h0000,16'h0000,8'h28,0};
    vt[12] = '{0,1,6,2'd3,16'h0000,6,3, 16'h0000,16'h0000,8'h28,0};
    vt[13] = '{0,1,7,2'd0,16'hABCD,7,6, 16'hABCD,16'h0000,8'h68,0};
    vt[14] = '{0,0,0,2'd0,16'h0000,7,7, 16'hABCD,16'hABCD,8'hE8,0};
    vt[15] = '{0,1,2,2'd0,16'h00AA,2,2, 16'h00AA,16'h00AA,8'hE8,0};
    vt[16] = '{0,0,0,2'd0,16'h0000,2,5, 16'h00AA,16'hFFFF,8'hEC,0};
    vt[17] = '{0,1,1,2'd0,16'h5555,1,1, 16'h5555,16'h5555,8'hEC,0};
    vt[18] = '{1,1,1,2'd0,16'h7777,1,2, 16'h5555,16'h00AA,8'hEE,0};
    vt[19] = '{0,0,0,2'd0,16'h0000,1,2, 16'h0000,16'h0000,8'h00,0};
    vt[20] = '{0,1,0,2'd2,16'h0000,0,1, 16'hFFFF,16'h0000,8'h00,0};
    vt[21] = '{0,0,0,2'd0,16'h0000,0,4, 16'hFFFF,16'h0000,8'h01,1};
    vt[22] = '{0,0,0,2'd1,16'h0000,0,4, 16'hFFFF,16'h0000,8'h01,0};
    vt[23] = '{0,0,0,2'd2,16'h0000,0,0, 16'hFFFF,16'hFFFF,8'h01,0};

    drive(1, 0, 0, 0, 16'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rst, vt[i].we, vt[i].waddr, vt[i].mode,
            vt[i].wdata, vt[i].ra, vt[i].rb);
      @(negedge clk);
      check($sformatf("v%0d rdata_a", i), 32'(rda0), 32'(vt[i].ea));
      check($sformatf("v%0d rdata_b", i), 32'(rdb0), 32'(vt[i].eb));
      check($sformatf("v%0d dirty", i), 32'(dirty0), 32'(vt[i].edirty));
      check($sformatf("v%0d overflow", i), 32'(ovf0), 32'(vt[i].eovf));
      next_cycle();
    end

    // Second instance: no forwarding, hard-wired zero register, 6 regs.
    drive(1, 0, 0, 0, 16'h0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 16'h0, 2, 5);
    @(negedge clk);
    check("u1 reset dirty", 32'(dirty1), 32'h0);
    check("u1 reset ovf", 32'(ovf1), 32'h0);
    next_cycle();

    drive(0, 1, 2, 2'd0, 16'h00AA, 2, 2);
    @(negedge clk);
    check("u1 nobypass a", 32'(rda1), 32'h0);
    check("u1 nobypass b", 32'(rdb1), 32'h0);
    next_cycle();
    drive(0, 0, 0, 2'd0, 16'h0, 2, 2);
    @(negedge clk);
    check("u1 after load a", 32'(rda1), 32'h00AA);
    check("u1 after load b", 32'(rdb1), 32'h00AA);
    check("u1 dirty r2", 32'(dirty1), 32'h04);
    next_cycle();

    drive(0, 1, 0, 2'd0, 16'hBEEF, 0, 0);
    @(negedge clk);
    check("u1 zero during wr", 32'(rda1), 32'h0);
    next_cycle();
    drive(0, 0, 0, 2'd0, 16'h0, 0, 2);
    @(negedge clk);
    check("u1 zero read", 32'(rda1), 32'h0);
    check("u1 zero dirty", 32'(dirty1), 32'h04);
    check("u1 zero ovf", 32'(ovf1), 32'h0);
    next_cycle();

    drive(0, 1, 7, 2'd0, 16'h1234, 6, 2);
    next_cycle();
    drive(0, 1, 6, 2'd3, 16'h4321, 6, 7);
    @(negedge clk);
    check("u1 oob dirty", 32'(dirty1), 32'h04);
    check("u1 oob read6", 32'(rda1), 32'h0);
    check("u1 oob read7", 32'(rdb1), 32'h0);
    next_cycle();
    drive(0, 0, 0, 2'd0, 16'h0, 6, 2);
    @(negedge clk);
    check("u1 oob dirty2", 32'(dirty1), 32'h04);
    check("u1 oob keep r2", 32'(rdb1), 32'h00AA);
    next_cycle();

    drive(0, 1, 0, 2'd2, 16'h0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 2'd0, 16'h0, 1, 0);
    @(negedge clk);
    check("u1 zero dec ovf", 32'(ovf1), 32'h0);
    next_cycle();

    drive(0, 1, 1, 2'd2, 16'h0, 1, 1);
    @(negedge clk);
    check("u1 dec old a", 32'(rda1), 32'h0);
    next_cycle();
    drive(0, 0, 0, 2'd0, 16'h0, 1, 2);
    @(negedge clk);
    check("u1 dec new a", 32'(rda1), 32'hFFFF);
    check("u1 dec ovf", 32'(ovf1), 32'h1);
    check("u1 dec dirty", 32'(dirty1), 32'h06);
    next_cycle();
    @(negedge clk);
    check("u1 ovf drop", 32'(ovf1), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
